// File: rtl/program_loader.sv
// program_loader: memory-bus front end ahead of the cpu core.
// A length byte N and then N big-endian 16-bit words arrive as a byte
// stream. Each word is written to program memory from address 0. The block
// then pulses cpu_execute and hands the memory bus to the CPU until the CPU
// reports cpu_halted, or until a run watchdog expires.
//
// Ports
//   clock, reset        system clock; synchronous active-low reset
//   start               begin a session (honoured in IDLE, DONE, ERROR)
//   in_data/in_valid    byte stream source
//   in_ready            byte accepted on this cycle's rising edge
//   cpu_execute         one-cycle start pulse to the CPU
//   cpu_halted          CPU finished
//   cpu_mem_*           CPU bus requests / read data returned to CPU
//   mem_*               memory bus
//   busy                session in progress
//   done                session ended with a CPU halt
//   error_code          0 none, 1 bad length, 2 run timeout
module program_loader #(
  parameter int WORD_SIZE      = 16,
  parameter int MEM_ADDR_SIZE  = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     cpu_execute,
  input  logic                     cpu_halted,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_mem_address,
  input  logic [WORD_SIZE-1:0]     cpu_mem_write_data,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  output logic [WORD_SIZE-1:0]     cpu_mem_read_data,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_read_data,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               error_code
);

  localparam int unsigned CNT_W = MEM_ADDR_SIZE + 1;
  localparam int unsigned DEPTH = 1 << MEM_ADDR_SIZE;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_RUN_START, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] k_inc;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [1:0]       err_q, err_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      k_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wdog_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      k_q     <= k_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // k counts in MEM_ADDR_SIZE+1 bits so a full-depth load (N == DEPTH)
  // terminates on k+1 == N without the address wrapping.
  assign k_inc      = k_q + CNT_W'(1);
  assign error_code = err_q;

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    k_d               = k_q;
    hi_d              = hi_q;
    lo_d              = lo_q;
    wdog_d            = wdog_q;
    err_d             = err_q;
    in_ready          = 1'b0;
    cpu_execute       = 1'b0;
    cpu_mem_read_data = '0;
    mem_address       = '0;
    mem_write_data    = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        busy = 1'b0;
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_LEN;
          k_d     = '0;
          wdog_d  = '0;
          err_d   = '0;
        end
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == '0 || 32'(in_data) > DEPTH) begin
            state_d = S_ERROR;
            err_d   = 2'd1;
          end else begin
            len_d   = CNT_W'(in_data);
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_d    = in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lo_d    = in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_write      = 1'b1;
        mem_address    = k_q[MEM_ADDR_SIZE-1:0];
        mem_write_data = WORD_SIZE'({hi_q, lo_q});
        k_d            = k_inc;
        state_d        = (k_inc == len_q) ? S_RUN_START : S_HI;
      end
      S_RUN_START, S_RUN: begin
        cpu_execute       = (state_q == S_RUN_START);
        mem_address       = cpu_mem_address;
        mem_write_data    = cpu_mem_write_data;
        mem_read          = cpu_mem_read;
        mem_write         = cpu_mem_write;
        cpu_mem_read_data = mem_read_data;
        if (state_q == S_RUN_START) begin
          state_d = S_RUN;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
          // Halt wins over an expiring watchdog on the same cycle.
          if (cpu_halted) begin
            state_d = S_DONE;
          end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_ERROR;
            err_d   = 2'd2;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cpu_execute;
  logic        cpu_halted = 1'b0;
  logic [4:0]  cpu_mem_address = '0;
  logic [15:0] cpu_mem_write_data = '0;
  logic        cpu_mem_read = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [15:0] cpu_mem_read_data;
  logic [4:0]  mem_address;
  logic [15:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_read_data = '0;
  logic        busy;
  logic        done;
  logic [1:0]  error_code;

  program_loader #(.WORD_SIZE(16), .MEM_ADDR_SIZE(5), .TIMEOUT_CYCLES(1024)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_execute(cpu_execute), .cpu_halted(cpu_halted),
    .cpu_mem_address(cpu_mem_address), .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_mem_read_data(cpu_mem_read_data),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .error_code(error_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  exec_due = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write is matched against the scoreboard; the word
  // flagged last must be followed by exactly one cpu_execute cycle.
  always @(negedge clock) begin : monitor
    wr_t e;
    cyc++;
    if (mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0d data %0h expected none", mem_address, mem_write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(e.a));
        chk("wr_data", 32'(mem_write_data), 32'(e.d));
        if (e.last) exec_due = cyc + 1;
      end
    end
    if (exec_due == cyc) begin
      chk("exec_pulse", 32'(cpu_execute), 1);
      exec_due = -1;
    end else if (cpu_execute) begin
      checks++;
      errors++;
      $display("FAIL unexpected_exec got 1 expected 0 at cycle %0d", cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (gap) @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      acc = in_ready;
      @(negedge clock);
      t++;
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
    if (!acc) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_exec();
    int t;
    t = 0;
    while (!cpu_execute && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (!cpu_execute) chk("exec_wait_timeout", 0, 1);
  endtask

  task automatic load_one(input logic [15:0] w);
    pulse_start();
    exp_q.push_back('{a: 5'd0, d: w, last: 1'b1});
    send_byte(8'd1, 0);
    send_byte(w[15:8], 0);
    send_byte(w[7:0], 0);
    wait_exec();
  endtask

  initial begin : stim
    int n;
    logic [7:0] hi, lo;

    // Reset with noisy inputs: everything must read zero.
    cpu_mem_read = 1'b1;
    cpu_mem_address = 5'd7;
    mem_read_data = 16'h1111;
    in_valid = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error_code), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_addr", 32'(mem_address), 0);
    chk("rst_rdata", 32'(cpu_mem_read_data), 0);
    start = 1'b0;
    in_valid = 1'b0;
    cpu_mem_read = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // N=2 load, then CPU bus pass-through and halt.
    pulse_start();
    chk("len_in_ready", 32'(in_ready), 1);
    chk("len_busy", 32'(busy), 1);
    exp_q.push_back('{a: 5'd0, d: 16'h1234, last: 1'b0});
    exp_q.push_back('{a: 5'd1, d: 16'hABCD, last: 1'b1});
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    wait_exec();
    @(negedge clock);
    cpu_mem_read = 1'b1;
    cpu_mem_address = 5'd3;
    mem_read_data = 16'hBEEF;
    #1;
    chk("run_mem_read", 32'(mem_read), 1);
    chk("run_mem_addr", 32'(mem_address), 3);
    chk("run_rdata", 32'(cpu_mem_read_data), 32'hBEEF);
    chk("run_in_ready", 32'(in_ready), 0);
    cpu_mem_write = 1'b1;
    cpu_mem_write_data = 16'h5A5A;
    #1;
    chk("run_mem_write", 32'(mem_write), 1);
    chk("run_wdata", 32'(mem_write_data), 32'h5A5A);
    cpu_mem_write = 1'b0;
    cpu_halted = 1'b1;
    @(negedge clock);
    #1;
    chk("halt_done", 32'(done), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_mem_read", 32'(mem_read), 0);
    chk("halt_mem_addr", 32'(mem_address), 0);
    chk("halt_rdata", 32'(cpu_mem_read_data), 0);
    cpu_halted = 1'b0;
    cpu_mem_write = 1'b1;
    #1;
    chk("done_mem_write", 32'(mem_write), 0);
    cpu_mem_write = 1'b0;
    cpu_mem_read = 1'b0;
    @(negedge clock);

    // Bad lengths 0 and 33.
    pulse_start();
    chk("start_clears_done", 32'(done), 0);
    send_byte(8'h00, 0);
    chk("len0_error", 32'(error_code), 1);
    chk("len0_in_ready", 32'(in_ready), 0);
    chk("len0_busy", 32'(busy), 0);
    pulse_start();
    chk("start_clears_err", 32'(error_code), 0);
    send_byte(8'h21, 0);
    chk("len33_error", 32'(error_code), 1);
    chk("len33_in_ready", 32'(in_ready), 0);

    // Full 32-word load with gaps and a stray start mid-load.
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      hi = 8'(i * 5 + 3);
      lo = 8'hF0 ^ 8'(i);
      exp_q.push_back('{a: 5'(i), d: {hi, lo}, last: (i == 31)});
    end
    send_byte(8'h20, 1);
    for (int i = 0; i < 32; i++) begin
      hi = 8'(i * 5 + 3);
      lo = 8'hF0 ^ 8'(i);
      if (i == 4) start = 1'b1;
      if (i == 8) start = 1'b0;
      send_byte(hi, int'($urandom_range(0, 2)));
      send_byte(lo, int'($urandom_range(0, 2)));
    end
    wait_exec();
    chk("full_all_written", 32'(exp_q.size()), 0);
    cpu_halted = 1'b1;
    repeat (2) @(negedge clock);
    chk("full_done", 32'(done), 1);
    cpu_halted = 1'b0;

    // Watchdog: exactly TIMEOUT_CYCLES RUN cycles, then error 2.
    load_one(16'h0001);
    n = 0;
    @(negedge clock);
    while (busy && n < 2000) begin
      n++;
      @(negedge clock);
    end
    chk("timeout_cycles", 32'(n), 1024);
    chk("timeout_error", 32'(error_code), 2);
    chk("timeout_done", 32'(done), 0);

    // Halt on the final watchdog cycle wins.
    load_one(16'h0002);
    repeat (1024) @(negedge clock);
    chk("last_run_busy", 32'(busy), 1);
    cpu_halted = 1'b1;
    @(negedge clock);
    chk("tie_done", 32'(done), 1);
    chk("tie_error", 32'(error_code), 0);
    cpu_halted = 1'b0;

    // Reset during WRITE.
    pulse_start();
    exp_q.push_back('{a: 5'd0, d: 16'hAABB, last: 1'b0});
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    chk("write_cycle", 32'(mem_write), 1);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11;
    @(negedge clock);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_in_ready", 32'(in_ready), 0);
    chk("rstw_mem_write", 32'(mem_write), 0);
    chk("rstw_mem_addr", 32'(mem_address), 0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("rstw_idle", 32'(in_ready), 0);

    // Reset during RUN.
    load_one(16'h0042);
    @(negedge clock);
    cpu_mem_read = 1'b1;
    cpu_mem_address = 5'd5;
    reset = 1'b0;
    @(negedge clock);
    chk("rstr_busy", 32'(busy), 0);
    chk("rstr_mem_read", 32'(mem_read), 0);
    chk("rstr_mem_addr", 32'(mem_address), 0);
    chk("rstr_rdata", 32'(cpu_mem_read_data), 0);
    reset = 1'b1;
    cpu_mem_read = 1'b0;
    @(negedge clock);

    // Reload after reset.
    pulse_start();
    exp_q.push_back('{a: 5'd0, d: 16'hCAFE, last: 1'b0});
    exp_q.push_back('{a: 5'd1, d: 16'h0102, last: 1'b1});
    send_byte(8'h02, 0);
    send_byte(8'hCA, 1);
    send_byte(8'hFE, 0);
    send_byte(8'h01, 2);
    send_byte(8'h02, 0);
    wait_exec();
    cpu_halted = 1'b1;
    repeat (2) @(negedge clock);
    chk("reload_done", 32'(done), 1);
    cpu_halted = 1'b0;
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
